// File: rtl/rf_writeback_queue.sv
// Write-back queue in front of the 32x32 register file write port.
// Buffers write requests, drains one per cycle, forwards queued data to rx/ry.
//
// Ports:
//   Clk, Reset              clock (rising edge), async active-low reset
//   in_valid/in_ready       write-back request handshake
//   in_rd, in_data          request destination register and data
//   drain_en                register file write port free this cycle
//   WEN, RW, busW           register file write port
//   rx, ry                  decode-stage read addresses
//   fwd_x_hit, fwd_x_data   youngest queued value for rx
//   fwd_y_hit, fwd_y_data   youngest queued value for ry
//   count, empty            occupancy
module rf_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 in_rd,
   input  logic [31:0]                in_data,
   input  logic                       drain_en,
   output logic                       WEN,
   output logic [4:0]                 RW,
   output logic [31:0]                busW,
   input  logic [4:0]                 rx,
   input  logic [4:0]                 ry,
   output logic                       fwd_x_hit,
   output logic [31:0]                fwd_x_data,
   output logic                       fwd_y_hit,
   output logic [31:0]                fwd_y_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [4:0]    rdQ   [DEPTH];
   logic [31:0]   dataQ [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          push;
   logic          pushStored;
   logic          pop;

   assign in_ready   = (count != FULL);
   assign empty      = (count == '0);
   assign push       = in_valid && in_ready;
   // writes to x0 are architecturally dead, so they never occupy a slot
   assign pushStored = push && (in_rd != 5'd0);
   assign pop        = drain_en && !empty;

   assign WEN  = pop;
   assign RW   = pop ? rdQ[rp]   : 5'd0;
   assign busW = pop ? dataQ[rp] : 32'd0;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (pushStored)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         case ({pushStored, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // slot contents need no reset: validity comes only from rp/count
   always_ff @(posedge Clk) begin
      if (pushStored) begin
         rdQ[wp]   <= in_rd;
         dataQ[wp] <= in_data;
      end
   end

   // walk oldest to youngest so the last match (youngest) wins
   always_comb begin
      logic [AW-1:0] slot;
      slot       = '0;
      fwd_x_hit  = 1'b0;
      fwd_x_data = 32'd0;
      fwd_y_hit  = 1'b0;
      fwd_y_data = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = rp + AW'(i);
         if (CW'(i) < count) begin
            if (rx != 5'd0 && rdQ[slot] == rx) begin
               fwd_x_hit  = 1'b1;
               fwd_x_data = dataQ[slot];
            end
            if (ry != 5'd0 && rdQ[slot] == ry) begin
               fwd_y_hit  = 1'b1;
               fwd_y_data = dataQ[slot];
            end
         end
      end
   end

endmodule
